// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the SRAM port arbiter.
// FSM state encoding and strobe-width helper.
package sram_port_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_D_ADDR = 3'd1,
    ST_D_WAIT = 3'd2,
    ST_I_ADDR = 3'd3,
    ST_I_WAIT = 3'd4
  } arbState_t;

  function automatic int strbW(int dataW);
    return dataW / 8;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_slot.sv
// Per-requester completion slot: done/discard flags and the
// rdata holding register that stays stable while the pipe is frozen.
//  clk/rst   clock, async active-high reset
//  active    this requester owns the in-flight bus transaction
//  respond   bus response for this requester this cycle
//  capture   response carries read data (loads/fetches)
//  clear     pipeline advanced; release the held result
//  flush     drop any in-flight result for this requester
//  rdataIn   bus read data
//  done      result available for the current request
//  rdata     held read data
module sram_port_arbiter_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              active,
  input  logic              respond,
  input  logic              capture,
  input  logic              clear,
  input  logic              flush,
  input  logic [DATA_W-1:0] rdataIn,
  output logic              done,
  output logic [DATA_W-1:0] rdata
);

  logic discard;
  logic drop;
  logic accept;

  // A flush arriving with the response drops it too.
  assign drop   = discard | (flush & active);
  assign accept = respond & ~drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done    <= 1'b0;
      discard <= 1'b0;
    end else begin
      // Setting wins over a same-cycle clear.
      if (accept)
        done <= 1'b1;
      else if (clear | flush)
        done <= 1'b0;

      if (respond)
        discard <= 1'b0;
      else if (flush & active)
        discard <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rdata <= '0;
    else if (accept & capture)
      rdata <= rdataIn;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like bus between instruction fetch and data access.
// Data has priority; one transaction outstanding; per-side stalls.
//  inst_*   fetch side: request level, address, held word, stall
//  data_*   M-stage side: request, wr, strobe, addr, wdata, held word, stall
//  pipe_adv pipeline advances (releases held results)
//  flush    discard in-flight fetch result
//  mem_*    bus request/address phase outputs and response inputs
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inst_req,
  input  logic [ADDR_W-1:0]         inst_addr,
  output logic [DATA_W-1:0]         inst_rdata,
  output logic                      inst_stall,
  input  logic                      data_req,
  input  logic                      data_wr,
  input  logic [strbW(DATA_W)-1:0]  data_wstrb,
  input  logic [ADDR_W-1:0]         data_addr,
  input  logic [DATA_W-1:0]         data_wdata,
  output logic [DATA_W-1:0]         data_rdata,
  output logic                      data_stall,
  input  logic                      pipe_adv,
  input  logic                      flush,
  output logic                      mem_req,
  output logic                      mem_wr,
  output logic [strbW(DATA_W)-1:0]  mem_wstrb,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_addr_ok,
  input  logic                      mem_data_ok,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int STRB_W = strbW(DATA_W);

  arbState_t state;
  arbState_t stateNext;

  logic              dDone;
  logic              iDone;
  logic              startD;
  logic              startI;
  logic              isAddr;
  logic              dResp;
  logic              iResp;
  logic              iActive;
  logic [ADDR_W-1:0] addrQ;
  logic              wrQ;
  logic [STRB_W-1:0] strbQ;
  logic [DATA_W-1:0] wdataQ;

  assign startD = (state == ST_IDLE) & data_req & ~dDone;
  // Never start a fetch on a flush cycle: inst_addr may be stale.
  assign startI = (state == ST_IDLE) & ~startD & inst_req
                & ~iDone & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      ST_IDLE: begin
        if (startD)
          stateNext = ST_D_ADDR;
        else if (startI)
          stateNext = ST_I_ADDR;
      end
      ST_D_ADDR: if (mem_addr_ok) stateNext = ST_D_WAIT;
      ST_D_WAIT: if (mem_data_ok) stateNext = ST_IDLE;
      ST_I_ADDR: if (mem_addr_ok) stateNext = ST_I_WAIT;
      ST_I_WAIT: if (mem_data_ok) stateNext = ST_IDLE;
      default:   stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    isAddr  = 1'b0;
    dResp   = 1'b0;
    iResp   = 1'b0;
    iActive = 1'b0;
    unique case (state)
      ST_D_ADDR: isAddr = 1'b1;
      ST_D_WAIT: dResp  = mem_data_ok;
      ST_I_ADDR: begin
        isAddr  = 1'b1;
        iActive = 1'b1;
      end
      ST_I_WAIT: begin
        iResp   = mem_data_ok;
        iActive = 1'b1;
      end
      default: ;
    endcase
  end

  // Bus fields are latched on entry so they stay stable
  // across any number of address-phase wait cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addrQ  <= '0;
      wrQ    <= 1'b0;
      strbQ  <= '0;
      wdataQ <= '0;
    end else if (startD) begin
      addrQ  <= data_addr;
      wrQ    <= data_wr;
      strbQ  <= data_wr ? data_wstrb : '0;
      wdataQ <= data_wdata;
    end else if (startI) begin
      addrQ  <= inst_addr;
      wrQ    <= 1'b0;
      strbQ  <= '0;
      wdataQ <= '0;
    end
  end

  assign mem_req   = isAddr;
  assign mem_wr    = isAddr & wrQ;
  assign mem_wstrb = isAddr ? strbQ : '0;
  assign mem_addr  = addrQ;
  assign mem_wdata = wdataQ;

  sram_port_arbiter_slot #(.DATA_W(DATA_W)) uDataSlot (
    .clk     (clk),
    .rst     (rst),
    .active  (1'b0),
    .respond (dResp),
    .capture (~wrQ),
    .clear   (pipe_adv),
    .flush   (1'b0),
    .rdataIn (mem_rdata),
    .done    (dDone),
    .rdata   (data_rdata)
  );

  sram_port_arbiter_slot #(.DATA_W(DATA_W)) uInstSlot (
    .clk     (clk),
    .rst     (rst),
    .active  (iActive),
    .respond (iResp),
    .capture (1'b1),
    .clear   (pipe_adv),
    .flush   (flush),
    .rdataIn (mem_rdata),
    .done    (iDone),
    .rdata   (inst_rdata)
  );

  assign data_stall = data_req & ~dDone;
  // Fetch is frozen while the M stage is stalled.
  assign inst_stall = (inst_req & ~iDone) | data_stall;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter.
// Hand-computed expectations checked with immediate assertions.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_stall;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_stall;
  logic        pipe_adv;
  logic        flush;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_rdata  (inst_rdata),
    .inst_stall  (inst_stall),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_wstrb  (data_wstrb),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_rdata  (data_rdata),
    .data_stall  (data_stall),
    .pipe_adv    (pipe_adv),
    .flush       (flush),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_wstrb   (mem_wstrb),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok),
    .mem_rdata   (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic advance();
    pipe_adv = 1'b1;
    tick();
    pipe_adv = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    inst_req = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_wstrb = 0;
    data_addr = 0; data_wdata = 0;
    pipe_adv = 0; flush = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 0);
    chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 0);
    chk("rst_istall", {31'd0, inst_stall}, 0);
    chk("rst_dstall", {31'd0, data_stall}, 0);
    chk("rst_irdata", inst_rdata, 0);
    chk("rst_drdata", data_rdata, 0);
    rst = 1'b0;

    // Fetch only, latency 1
    inst_req = 1; inst_addr = 32'h0040_0000;
    #1;
    chk("f_stall0", {31'd0, inst_stall}, 1);
    tick();
    chk("f_req", {31'd0, mem_req}, 1);
    chk("f_addr", mem_addr, 32'h0040_0000);
    chk("f_wr", {31'd0, mem_wr}, 0);
    mem_addr_ok = 1;
    tick();
    chk("f_wait_req", {31'd0, mem_req}, 0);
    chk("f_wait_stall", {31'd0, inst_stall}, 1);
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h2402_0001;
    tick();
    mem_data_ok = 0;
    chk("f_stall_low", {31'd0, inst_stall}, 0);
    chk("f_rdata", inst_rdata, 32'h2402_0001);
    chk("f_idle_req", {31'd0, mem_req}, 0);
    inst_req = 0;
    advance();

    // Simultaneous fetch and load: data first
    inst_req = 1; inst_addr = 32'h0040_0004;
    data_req = 1; data_wr = 0; data_addr = 32'h8000_0010;
    data_wstrb = 4'hF;
    #1;
    chk("s_dstall", {31'd0, data_stall}, 1);
    chk("s_istall", {31'd0, inst_stall}, 1);
    tick();
    chk("s_d_req", {31'd0, mem_req}, 1);
    chk("s_d_addr", mem_addr, 32'h8000_0010);
    chk("s_d_wr", {31'd0, mem_wr}, 0);
    chk("s_d_strb", {28'd0, mem_wstrb}, 0);
    mem_addr_ok = 1;
    tick();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h1122_3344;
    tick();
    mem_data_ok = 0;
    chk("s_d_rdata", data_rdata, 32'h1122_3344);
    chk("s_d_stall", {31'd0, data_stall}, 0);
    chk("s_i_still", {31'd0, inst_stall}, 1);
    tick();
    chk("s_i_req", {31'd0, mem_req}, 1);
    chk("s_i_addr", mem_addr, 32'h0040_0004);
    mem_addr_ok = 1;
    tick();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h8C43_0000;
    tick();
    mem_data_ok = 0;
    chk("s_i_rdata", inst_rdata, 32'h8C43_0000);
    chk("s_i_stall", {31'd0, inst_stall}, 0);
    chk("s_d_keep", data_rdata, 32'h1122_3344);
    chk("s_idle_req", {31'd0, mem_req}, 0);
    inst_req = 0; data_req = 0;
    advance();

    // Store with 3-cycle addr_ok delay
    data_req = 1; data_wr = 1; data_wstrb = 4'b0011;
    data_addr = 32'h8000_0020; data_wdata = 32'hDEAD_BEEF;
    tick();
    data_wdata = 32'h0; data_wstrb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      chk("st_req", {31'd0, mem_req}, 1);
      chk("st_wr", {31'd0, mem_wr}, 1);
      chk("st_addr", mem_addr, 32'h8000_0020);
      chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("st_strb", {28'd0, mem_wstrb}, 32'h3);
      if (i == 2) mem_addr_ok = 1;
      tick();
    end
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_data_ok = 0;
    chk("st_drdata", data_rdata, 32'h1122_3344);
    chk("st_dstall", {31'd0, data_stall}, 0);
    data_req = 0; data_wr = 0; data_wstrb = 0;
    advance();

    // Load result held while pipe frozen
    data_req = 1; data_addr = 32'h8000_0030;
    tick();
    mem_addr_ok = 1;
    tick();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_data_ok = 0; mem_rdata = 32'h0BAD_BAD0;
    for (int i = 0; i < 4; i++) begin
      chk("h_rdata", data_rdata, 32'hCAFE_F00D);
      chk("h_stall", {31'd0, data_stall}, 0);
      chk("h_req", {31'd0, mem_req}, 0);
      mem_data_ok = (i == 1);
      tick();
    end
    mem_data_ok = 0;
    chk("h_stray", data_rdata, 32'hCAFE_F00D);
    data_req = 0;
    advance();
    chk("h_rel_stall", {31'd0, data_stall}, 0);

    // Flush during I_WAIT
    inst_req = 1; inst_addr = 32'h0040_0008;
    tick();
    mem_addr_ok = 1;
    tick();
    mem_addr_ok = 0; flush = 1;
    tick();
    flush = 0; inst_addr = 32'hBFC0_0380;
    mem_data_ok = 1; mem_rdata = 32'h1234_5678;
    tick();
    mem_data_ok = 0;
    chk("fl_rdata", inst_rdata, 32'h8C43_0000);
    chk("fl_stall", {31'd0, inst_stall}, 1);
    chk("fl_idle", {31'd0, mem_req}, 0);
    tick();
    chk("fl_req", {31'd0, mem_req}, 1);
    chk("fl_addr", mem_addr, 32'hBFC0_0380);
    mem_addr_ok = 1;
    tick();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h3C1A_0000;
    tick();
    mem_data_ok = 0;
    chk("fl_new", inst_rdata, 32'h3C1A_0000);
    chk("fl_nstall", {31'd0, inst_stall}, 0);
    inst_req = 0;
    advance();

    // Reset in D_WAIT
    data_req = 1; data_addr = 32'h8000_0040;
    tick();
    mem_addr_ok = 1;
    tick();
    mem_addr_ok = 0;
    rst = 1; data_req = 0;
    #1;
    chk("r_req", {31'd0, mem_req}, 0);
    chk("r_drdata", data_rdata, 0);
    chk("r_irdata", inst_rdata, 0);
    tick();
    rst = 0; mem_data_ok = 1; mem_rdata = 32'h5555_5555;
    tick();
    mem_data_ok = 0;
    chk("r_stray", data_rdata, 0);
    chk("r_idle", {31'd0, mem_req}, 0);
    chk("r_dstall", {31'd0, data_stall}, 0);
    data_req = 1; data_addr = 32'h8000_0044;
    tick();
    chk("r_again", mem_addr, 32'h8000_0044);
    chk("r_again_req", {31'd0, mem_req}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
